// File: rtl/prog_seq_pkg.sv
// Shared opcode constants and FSM state type for the program sequencer.
package prog_seq_pkg;

  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] OP_ILL0 = 3'b101;
  localparam logic [2:0] OP_ILL1 = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prog_buffer.sv
// Program storage: append-only write port, combinational read at the issue pointer.
module prog_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Loads a short 16-bit program from a host and issues it to the datapath IR,
// free-running or single-stepped, stopping on HALT, illegal opcode or program end.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  input  logic [15:0]   load_instr_i,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic          abort_i,
  input  logic          step_mode_i,
  input  logic          step_i,
  output logic [15:0]   instr_out_o,
  output logic          instr_valid_o,
  output logic [AW:0]   pc_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   issued_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d, pc_q, pc_d, issued_q, issued_d;
  logic [15:0] instr_q, instr_d, rdata;
  logic        valid_q, valid_d, err_q, err_d, rdy_q, rdy_d;
  logic        we, accept, issue;
  logic [2:0]  op;

  prog_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (load_instr_i),
    .raddr_i (pc_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign accept = load_valid_i && rdy_q;
  assign issue  = !step_mode_i || step_i;
  assign op     = rdata[15:13];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    we       = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
      pc_d    = '0;
      err_d   = 1'b0;
    end else if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we      = 1'b1;
            count_d = count_q + ONE;
          end
          // A word landing on the same edge as start counts as a non-empty program.
          if (start_i) begin
            if (count_q != '0 || accept) begin
              state_d  = RUN;
              pc_d     = '0;
              issued_d = '0;
              err_d    = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (op == OP_HALT) begin
              state_d = DONE;
            end else if (op == OP_ILL0 || op == OP_ILL1) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              instr_d  = rdata;
              valid_d  = 1'b1;
              pc_d     = pc_q + ONE;
              issued_d = issued_q + ONE;
              if (pc_q == count_q - ONE) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state_d  = RUN;
            pc_d     = '0;
            issued_d = '0;
            err_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    rdy_d = (state_d == IDLE) && (count_d < DEPTH_W);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pc_q     <= '0;
      issued_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign load_ready_o  = rdy_q;
  assign instr_out_o   = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign count_o       = count_q;
  assign issued_o      = issued_q;
  assign busy_o        = (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign error_o       = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed-vector bench for prog_sequencer with hand-computed expectations.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset, load_valid, start, clear, abort, step_mode, step;
  logic [15:0] load_instr;
  logic        load_ready, instr_valid, busy, done, error;
  logic [15:0] instr_out;
  logic [4:0]  pc, count, issued;

  int total = 0;
  int bad   = 0;
  logic [15:0] prog [$];

  always #5 clk = ~clk;

  prog_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_instr_i  (load_instr),
    .start_i       (start),
    .clear_i       (clear),
    .abort_i       (abort),
    .step_mode_i   (step_mode),
    .step_i        (step),
    .instr_out_o   (instr_out),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .count_o       (count),
    .issued_o      (issued),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      load_valid = 1'b1;
      load_instr = prog[i];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_instr = '0; start = 1'b0;
    clear = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick();
    chk("rst_rdy", load_ready, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_cnt", count, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {busy, done, error}, 0);
    reset = 1'b0;
    tick();
    chk("idle_rdy", load_ready, 1);

    // Straight 4-word program, no HALT
    prog = '{16'h4006, 16'h40BF, 16'h8904, 16'h8BBF};
    load_prog();
    chk("t1_cnt", count, 4);
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_v0", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_v%0d", i + 1), instr_valid, 1);
      chk($sformatf("t1_i%0d", i + 1), instr_out, prog[i]);
    end
    chk("t1_done", done, 1);
    tick();
    chk("t1_vfall", instr_valid, 0);
    chk("t1_hold", instr_out, 16'h8BBF);
    chk("t1_iss", issued, 4);
    chk("t1_err", error, 0);
    chk("t1_pc", pc, 4);

    // HALT at pc=1
    do_clear();
    chk("t2_clr", count, 0);
    prog = '{16'h4006, 16'hE000, 16'h40BF};
    load_prog();
    do_start();
    tick();
    chk("t2_v1", instr_valid, 1);
    chk("t2_i1", instr_out, 16'h4006);
    tick();
    chk("t2_v2", instr_valid, 0);
    chk("t2_done", done, 1);
    chk("t2_iss", issued, 1);
    chk("t2_pc", pc, 1);

    // Illegal opcode 101
    do_clear();
    prog = '{16'h20D0, 16'hA000};
    load_prog();
    do_start();
    tick();
    chk("t3_i1", instr_out, 16'h20D0);
    chk("t3_v1", instr_valid, 1);
    tick();
    chk("t3_v2", instr_valid, 0);
    chk("t3_err", error, 1);
    chk("t3_done", done, 1);
    chk("t3_iss", issued, 1);

    // Fill to capacity, then start on empty buffer
    do_clear();
    chk("t4_errclr", error, 0);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t4_rdy%0d", i), load_ready, (i < 16) ? 1 : 0);
      load_valid = 1'b1;
      load_instr = 16'(16'h4000 + i);
      tick();
    end
    load_valid = 1'b0;
    chk("t4_cnt", count, 16);
    do_clear();
    do_start();
    chk("t4_err", error, 1);
    chk("t4_idle", {busy, done}, 0);

    // Single-step: pulses on edges E+3 and E+7
    do_clear();
    prog = '{16'h4006, 16'h40BF};
    load_prog();
    step_mode = 1'b1;
    do_start();
    for (int k = 1; k <= 8; k++) begin
      step = (k == 3 || k == 7);
      tick();
      step = 1'b0;
      chk($sformatf("t5_v%0d", k), instr_valid, (k == 3 || k == 7) ? 1 : 0);
      if (k == 3) chk("t5_i3", instr_out, 16'h4006);
      if (k == 7) chk("t5_i7", instr_out, 16'h40BF);
      chk($sformatf("t5_d%0d", k), done, (k >= 7) ? 1 : 0);
    end
    step_mode = 1'b0;

    // Reset mid-run, then abort mid-run
    do_clear();
    prog = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004, 16'h4005, 16'h4006, 16'h4007};
    load_prog();
    do_start();
    tick();
    tick();
    chk("t6_run", instr_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rv", instr_valid, 0);
    chk("t6_rc", count, 0);
    chk("t6_rb", busy, 0);
    tick();
    load_prog();
    do_start();
    tick();
    tick();
    chk("t6_i2", instr_out, 16'h4001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_ab", busy, 0);
    chk("t6_av", instr_valid, 0);
    chk("t6_ac", count, 8);
    chk("t6_ad", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer for the 8-bit instruction-processing datapath (IR, control unit, 8x8 register file, ALU). A host loads a short program of 16-bit instructions into an internal buffer. On `start`, the block issues the instructions one per cycle, or one per `step` pulse, on `instr_out`/`instr_valid`. It stops on a HALT opcode, an illegal opcode, or the end of the program. The datapath's IR input connects to `instr_out`, and the top level qualifies the datapath `regWrite` with `instr_valid`.

## Interface
- `DEPTH`, 16, number of buffer entries; must be a power of two.
- `AW`, 4, buffer address width; equals log2(`DEPTH`).
- `clk` input 1: all state updates on posedge, so `instr_out` is stable before the datapath's negedge capture.
- `reset` input 1: reset, synchronous, active-high.
- `load_valid` input 1: host offers `load_instr`.
- `load_ready` output 1: buffer accepts a word this cycle.
- `load_instr` input 16: instruction word to append.
- `start` input 1: begin execution from entry 0.
- `clear` input 1: empty the buffer and return to IDLE.
- `abort` input 1: stop a run and return to IDLE; the program is kept.
- `step_mode` input 1: when 1, one instruction is issued per `step` pulse.
- `step` input 1: single-step advance; sampled only in RUN with `step_mode`=1.
- `instr_out` output 16: instruction to the datapath IR.
- `instr_valid` output 1: `instr_out` is a real instruction this cycle.
- `pc` output AW+1: index of the next entry to issue.
- `count` output AW+1: number of words loaded.
- `issued` output AW+1: number of instructions issued in the current or last run.
- `busy` output 1: state is RUN.
- `done` output 1: state is DONE.
- `error` output 1: sticky; set by an illegal opcode or by `start` with an empty buffer.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: all outputs 0; `count`, `pc` and `issued` are 0. Buffer contents are don't-care.
- **IDLE**
  - `load_ready` = (`count` < `DEPTH`).
  - Handshake `load_valid`&`load_ready` writes `mem[count]` and increments `count`.
  - `start` with `count`>0, or with a word accepted on the same edge: go to RUN; `pc`←0, `issued`←0, `error`←0.
  - `start` with `count`=0 and no accepted word: `error`←1, stay in IDLE.
- **RUN**
  - `load_ready`=0.
  - An issue edge is every edge when `step_mode`=0, or an edge with `step`=1 when `step_mode`=1.
  - Non-issue edge: `instr_valid`←0, `pc` held.
  - Issue edge, `mem[pc][15:13]` = 3'b111 (HALT): not issued; `instr_valid`←0; go to DONE.
  - Issue edge, opcode 3'b101 or 3'b110 (illegal): not issued; `instr_valid`←0; `error`←1; go to DONE.
  - Issue edge, otherwise: `instr_out`←`mem[pc]`, `instr_valid`←1, `pc`++, `issued`++. If `pc` = `count`-1, go to DONE on the same edge.
- **DONE**
  - `instr_valid`←0; `instr_out` holds its last value.
  - `start` re-runs the same program from `pc`=0.
- Priority on any single edge: `reset` > `clear` > `abort` > `start` > load.
  - `clear` sets `count`←0, `pc`←0, `error`←0 and goes to IDLE.
  - `abort` in RUN or DONE sets `instr_valid`←0 and goes to IDLE, keeping `count`.

## Timing
- Latency: `start` sampled at edge E, first `instr_valid` after edge E+1. Back-to-back issue afterwards when `step_mode`=0.
- N-word program without HALT: `instr_valid` is high for edges E+1..E+N, `done` rises after edge E+N, `instr_valid` falls after edge E+N+1.
- HALT at `pc`=k: `done` rises one edge after the edge that issued word k-1, with `instr_valid` low.
- `step_mode` may toggle mid-run and takes effect on the next edge.
- Reset mid-run: RUN is abandoned immediately, `instr_valid`=0 after that edge, buffer emptied.
- `count` saturates at `DEPTH`; `load_ready` is low when the buffer is full.

## Structure
- Package `prog_seq_pkg`: opcode constants OP_HALT=3'b111, OP_ILL0=3'b101, OP_ILL1=3'b110, and the state enum {IDLE, RUN, DONE}.
- Sub-module `prog_buffer`: DEPTH×16 storage with append port (we, wdata, count) and combinational read at `pc`. The sequencer FSM lives in the top module.

## Test plan
- Load 4006, 40BF, 8904, 8BBF; `start` -> `instr_valid` for 4 consecutive cycles in that order, then `done`=1, `issued`=4, `error`=0.
- Load 4006, E000, 40BF; `start` -> only 4006 issued, `done`=1, `issued`=1, `pc`=1.
- Load 20D0, A000; `start` -> 20D0 issued, then `error`=1, `done`=1, `issued`=1.
- Offer 17 words in IDLE -> 16 accepted, `load_ready`=0 on the 17th, `count`=16; `start` with `count`=0 after `clear` -> `error`=1 and state stays IDLE.
- `step_mode`=1 with `step` pulsed on cycles 3 and 7 after `start`, program 4006, 40BF -> `instr_valid` exactly on those two edges, then `done`.
- `reset` asserted two cycles into an 8-word run -> `instr_valid`=0, `count`=0, `busy`=0 after that edge; `abort` in RUN -> IDLE with `count` retained.
